// File: rtl/gate_tt_pkg.sv
// Shared gate encodings, checker FSM states and the expected-output function.
package gate_tt_pkg;

  localparam logic [2:0] GATE_BUF  = 3'd0;
  localparam logic [2:0] GATE_NOT  = 3'd1;
  localparam logic [2:0] GATE_AND  = 3'd2;
  localparam logic [2:0] GATE_NAND = 3'd3;
  localparam logic [2:0] GATE_OR   = 3'd4;
  localparam logic [2:0] GATE_NOR  = 3'd5;
  localparam logic [2:0] GATE_XOR  = 3'd6;
  localparam logic [2:0] GATE_XNOR = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Reductions cover only the low n bits of vec; the rest are ignored.
  function automatic logic expected_out(
    input logic [2:0] sel,
    input logic [3:0] vec,
    input int         n
  );
    logic a;
    logic o;
    logic x;
    logic r;
    a = 1'b1;
    o = 1'b0;
    x = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        a = a & vec[i];
        o = o | vec[i];
        x = x ^ vec[i];
      end
    end
    unique case (sel)
      GATE_BUF:  r = vec[0];
      GATE_NOT:  r = ~vec[0];
      GATE_AND:  r = a;
      GATE_NAND: r = ~a;
      GATE_OR:   r = o;
      GATE_NOR:  r = ~o;
      GATE_XOR:  r = x;
      GATE_XNOR: r = ~x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_tt_checker_ref.sv
// Combinational reference model of the gate selected by sel.
module gate_tt_ref
  import gate_tt_pkg::*;
#(
  parameter int NUM_IN = 2
) (
  input  logic [2:0]        sel,
  input  logic [NUM_IN-1:0] vec,
  output logic              exp_out
);

  logic [3:0] v4;

  always_comb begin
    v4 = '0;
    v4[NUM_IN-1:0] = vec;
    exp_out = expected_out(sel, v4, NUM_IN);
  end

endmodule

// File: rtl/gate_tt_checker.sv
// Truth-table sweeper/checker for a single-output gate under test.
// Optional first-mismatch capture port enabled by TT_FIRST_FAIL_EN.
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        gate_sel,
  input  logic              dut_out,
  output logic [NUM_IN-1:0] stim,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [NUM_IN:0]   err_count
`ifdef TT_FIRST_FAIL_EN
  ,
  output logic [NUM_IN:0]   first_fail
`endif
);

  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);
  localparam logic [NUM_IN-1:0] LAST = '1;
  localparam logic [NUM_IN:0] ERR_MAX = '1;

  state_t          state;
  logic [2:0]      sel_q;
  logic [CW-1:0]   cnt;
  logic            exp_bit;
  logic            mismatch;
  logic [NUM_IN:0] err_nxt;

  gate_tt_ref #(
    .NUM_IN(NUM_IN)
  ) u_ref (
    .sel    (sel_q),
    .vec    (stim),
    .exp_out(exp_bit)
  );

  assign mismatch = (dut_out != exp_bit);

  always_comb begin
    err_nxt = err_count;
    if (mismatch && (err_count != ERR_MAX))
      err_nxt = err_count + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel_q     <= '0;
      cnt       <= '0;
      stim      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
`ifdef TT_FIRST_FAIL_EN
      first_fail <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sel_q     <= gate_sel;
            err_count <= '0;
            pass      <= 1'b0;
            stim      <= '0;
            busy      <= 1'b1;
            state     <= ST_DRIVE;
`ifdef TT_FIRST_FAIL_EN
            first_fail <= '0;
`endif
          end
        end
        ST_DRIVE: begin
          cnt   <= SETTLE_LD;
          state <= (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;
        end
        ST_SETTLE: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1))
            state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          err_count <= err_nxt;
`ifdef TT_FIRST_FAIL_EN
          if (mismatch && !first_fail[NUM_IN])
            first_fail <= {1'b1, stim};
`endif
          if (stim == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
            state <= ST_DONE;
          end else begin
            stim  <= stim + 1'b1;
            state <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          stim  <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/gate_tt_checker.md
Name: gate_tt_checker

Overview:
Self-sequencing truth-table checker for single-output combinational gates under test. It sweeps every input combination onto the gate, waits a fixed settle time, samples the gate output and compares it with the expected value for the selected gate function. It replaces hand-written stimulus/monitor benches with a synthesizable sweeper that reports pass/fail and an error count.

Parameters:
NUM_IN, 2, number of gate inputs driven (1..4); BUF/NOT use stim[0] only
SETTLE, 2, idle cycles between driving stim and sampling dut_out (>=0)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a sweep; sampled only in IDLE
gate_sel  input  3  0 BUF, 1 NOT, 2 AND, 3 NAND, 4 OR, 5 NOR, 6 XOR, 7 XNOR
dut_out  input  1  output of gate under test
stim  output  NUM_IN  input vector applied to gate under test
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse at end of sweep
pass  output  1  valid when done=1 and held until next start; 1 iff err_count==0
err_count  output  NUM_IN+1  mismatches in last/current sweep

Behaviour:
- Reset (async, any state): state=IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, settle counter=0; gate_sel latch=0.
- IDLE: on start=1, latch gate_sel, clear err_count and pass, stim=0, go DRIVE. gate_sel changes after this point are ignored until the next sweep.
- DRIVE (1 cycle): stim holds current vector; load settle counter with SETTLE; go SETTLE if SETTLE>0, else SAMPLE.
- SETTLE: decrement counter each cycle; on reaching 0 go SAMPLE.
- SAMPLE (1 cycle): compare dut_out with expected(gate_sel_latched, stim); on mismatch err_count+=1 (saturating at all-ones). If stim == 2^NUM_IN-1, go DONE; else stim+=1 (no wrap observed), go DRIVE.
- DONE (1 cycle): done=1, pass=(err_count==0), busy=0; return IDLE. stim returns to 0 on entering IDLE.
- Cycles per vector: SETTLE+2. Sweep latency start->done = 2^NUM_IN*(SETTLE+2)+1 cycles.
- Expected function: reduction over all NUM_IN bits for AND/NAND/OR/NOR/XOR/XNOR; BUF = stim[0], NOT = ~stim[0].
- start while busy: ignored. start asserted in the DONE cycle: ignored; start must be asserted again in IDLE.
- Reset mid-sweep: sweep abandoned, no done pulse, all outputs at their reset values.
- pass and err_count hold their values in IDLE until the next accepted start.

Optional Feature:
Macro TT_FIRST_FAIL_EN. When defined: adds output first_fail [NUM_IN:0]; bit NUM_IN is a valid flag and the low bits hold the stim of the first mismatching vector in the sweep. Cleared on start and on reset, and written once per sweep. When undefined: the port is absent and no capture logic is built; all other behaviour is identical.

Decomposition:
- Package gate_tt_pkg: gate_sel encodings as constants (GATE_BUF..GATE_XNOR), FSM state enum (IDLE, DRIVE, SETTLE, SAMPLE, DONE), and function expected_out(sel, vec).
- One sub-module, gate_tt_ref: a purely combinational reference model wrapping expected_out, so benches can reuse it. The FSM, counters and compare logic stay in the top.

Test Plan:
- NUM_IN=2, SETTLE=2, gate_sel=7 (XNOR), dut wired as a correct xnor -> stim sequence 0,1,2,3; done at cycle 17 after start; pass=1, err_count=0.
- gate_sel=3 (NAND), dut wired as AND -> err_count=4, pass=0; with TT_FIRST_FAIL_EN defined, first_fail=3'b100.
- gate_sel=0 (BUF), dut_out=stim[0] -> pass=1. gate_sel=1 (NOT) with the same wiring -> err_count=4.
- SETTLE=0, gate_sel=4 (OR), dut stuck at 1 -> only vector 0 mismatches; err_count=1; done 9 cycles after start.
- Assert rst at vector 2 mid-sweep -> outputs go to 0 immediately with no done pulse; a new start completes a normal sweep.
- Pulse start while busy, and toggle gate_sel mid-sweep -> no restart; the result uses the latched gate_sel.
